// File: rtl/instr_decode_pkg.sv
// Types shared between the new6502 decoder and the CPU control path.
package common_types;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [5:0] {
    ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC,
    CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP,
    JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI,
    RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA,
    ILL
  } opc_t;

  typedef enum logic [3:0] {
    IMP, ACC, IMM, ZP, ZPX, ZPY, ABS, ABSX, ABSY, IND, INDX, INDY, REL
  } addmod_t;

endpackage

// File: rtl/instr_decode.sv
// Registered NMOS 6502 opcode decoder: opcode byte -> mnemonic class,
// addressing mode and an illegal-opcode flag, one cycle after sampling.
module instr_decode
  import common_types::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  data_t   instr,
  output opc_t    opcode,
  output addmod_t mode,
  output logic    illegal
);

  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;
  opc_t       opc_dec;
  addmod_t    mode_dec;
  logic       legal_dec;
  opc_t       opc_next;
  addmod_t    mode_next;
  logic       illegal_next;

  assign aaa = instr[7:5];
  assign bbb = instr[4:2];
  assign cc  = instr[1:0];

  always_comb begin
    opc_dec   = ILL;
    mode_dec  = IMP;
    legal_dec = 1'b0;
    unique case (cc)
      2'b01: begin
        legal_dec = (instr != 8'h89);  // would be STA #imm
        case (aaa)
          3'd0:    opc_dec = ORA;
          3'd1:    opc_dec = AND;
          3'd2:    opc_dec = EOR;
          3'd3:    opc_dec = ADC;
          3'd4:    opc_dec = STA;
          3'd5:    opc_dec = LDA;
          3'd6:    opc_dec = CMP;
          default: opc_dec = SBC;
        endcase
        case (bbb)
          3'd0:    mode_dec = INDX;
          3'd1:    mode_dec = ZP;
          3'd2:    mode_dec = IMM;
          3'd3:    mode_dec = ABS;
          3'd4:    mode_dec = INDY;
          3'd5:    mode_dec = ZPX;
          3'd6:    mode_dec = ABSY;
          default: mode_dec = ABSX;
        endcase
      end
      2'b10: begin
        case (aaa)
          3'd0:    opc_dec = ASL;
          3'd1:    opc_dec = ROL;
          3'd2:    opc_dec = LSR;
          3'd3:    opc_dec = ROR;
          3'd4:    opc_dec = STX;
          3'd5:    opc_dec = LDX;
          3'd6:    opc_dec = DEC;
          default: opc_dec = INC;
        endcase
        case (bbb)
          3'd0: begin
            legal_dec = (instr == 8'hA2);
            mode_dec  = IMM;
          end
          3'd1: begin
            legal_dec = 1'b1;
            mode_dec  = ZP;
          end
          3'd3: begin
            legal_dec = 1'b1;
            mode_dec  = ABS;
          end
          3'd5: begin
            legal_dec = 1'b1;
            mode_dec  = (aaa == 3'd4 || aaa == 3'd5) ? ZPY : ZPX;
          end
          3'd7: begin
            legal_dec = (instr != 8'h9E);
            mode_dec  = (instr == 8'hBE) ? ABSY : ABSX;
          end
          3'd2: begin
            // Upper half of this column is register transfers, not shifts.
            legal_dec = 1'b1;
            mode_dec  = aaa[2] ? IMP : ACC;
            case (aaa)
              3'd4:    opc_dec = TXA;
              3'd5:    opc_dec = TAX;
              3'd6:    opc_dec = DEX;
              3'd7:    opc_dec = NOP;
              default: ;
            endcase
          end
          3'd6: begin
            legal_dec = (instr == 8'h9A) || (instr == 8'hBA);
            mode_dec  = IMP;
            opc_dec   = (instr == 8'h9A) ? TXS : TSX;
          end
          default: legal_dec = 1'b0;
        endcase
      end
      2'b00: begin
        legal_dec = 1'b1;
        case (instr)
          8'h10: begin opc_dec = BPL; mode_dec = REL; end
          8'h30: begin opc_dec = BMI; mode_dec = REL; end
          8'h50: begin opc_dec = BVC; mode_dec = REL; end
          8'h70: begin opc_dec = BVS; mode_dec = REL; end
          8'h90: begin opc_dec = BCC; mode_dec = REL; end
          8'hB0: begin opc_dec = BCS; mode_dec = REL; end
          8'hD0: begin opc_dec = BNE; mode_dec = REL; end
          8'hF0: begin opc_dec = BEQ; mode_dec = REL; end
          8'h00: opc_dec = BRK;
          8'h08: opc_dec = PHP;
          8'h18: opc_dec = CLC;
          8'h28: opc_dec = PLP;
          8'h38: opc_dec = SEC;
          8'h40: opc_dec = RTI;
          8'h48: opc_dec = PHA;
          8'h58: opc_dec = CLI;
          8'h60: opc_dec = RTS;
          8'h68: opc_dec = PLA;
          8'h78: opc_dec = SEI;
          8'h88: opc_dec = DEY;
          8'h98: opc_dec = TYA;
          8'hA8: opc_dec = TAY;
          8'hB8: opc_dec = CLV;
          8'hC8: opc_dec = INY;
          8'hD8: opc_dec = CLD;
          8'hE8: opc_dec = INX;
          8'hF8: opc_dec = SED;
          8'h20: begin opc_dec = JSR; mode_dec = ABS; end
          8'h2C: begin opc_dec = BIT; mode_dec = ABS; end
          8'h4C: begin opc_dec = JMP; mode_dec = ABS; end
          8'h8C: begin opc_dec = STY; mode_dec = ABS; end
          8'hAC: begin opc_dec = LDY; mode_dec = ABS; end
          8'hCC: begin opc_dec = CPY; mode_dec = ABS; end
          8'hEC: begin opc_dec = CPX; mode_dec = ABS; end
          8'h6C: begin opc_dec = JMP; mode_dec = IND; end
          8'h24: begin opc_dec = BIT; mode_dec = ZP; end
          8'h84: begin opc_dec = STY; mode_dec = ZP; end
          8'hA4: begin opc_dec = LDY; mode_dec = ZP; end
          8'hC4: begin opc_dec = CPY; mode_dec = ZP; end
          8'hE4: begin opc_dec = CPX; mode_dec = ZP; end
          8'h94: begin opc_dec = STY; mode_dec = ZPX; end
          8'hB4: begin opc_dec = LDY; mode_dec = ZPX; end
          8'hBC: begin opc_dec = LDY; mode_dec = ABSX; end
          8'hA0: begin opc_dec = LDY; mode_dec = IMM; end
          8'hC0: begin opc_dec = CPY; mode_dec = IMM; end
          8'hE0: begin opc_dec = CPX; mode_dec = IMM; end
          default: legal_dec = 1'b0;
        endcase
      end
      default: legal_dec = 1'b0;
    endcase
  end

  // Illegal bytes always collapse to a single canonical output.
  always_comb begin
    opc_next     = legal_dec ? opc_dec  : ILL;
    mode_next    = legal_dec ? mode_dec : IMP;
    illegal_next = ~legal_dec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode  <= NOP;
      mode    <= IMP;
      illegal <= 1'b0;
    end else begin
      opcode  <= opc_next;
      mode    <= mode_next;
      illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode against a table-driven opcode map.
module tb_instr_decode;
  import common_types::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  data_t   instr = 8'h00;
  opc_t    opcode;
  addmod_t mode;
  logic    illegal;

  int tests = 0;
  int fails = 0;

  opc_t    gold_opc  [256];
  addmod_t gold_mode [256];
  bit      gold_legal[256];

  instr_decode dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .instr  (instr),
    .opcode (opcode),
    .mode   (mode),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic void add(input int b, input opc_t o, input addmod_t m);
    gold_opc[b]   = o;
    gold_mode[b]  = m;
    gold_legal[b] = 1'b1;
  endfunction

  // Golden map assembled mnemonic by mnemonic from the documented opcode lists.
  function automatic void build_golden();
    opc_t alu[8];
    addmod_t alu_mode[8];
    opc_t shf[4];
    alu      = '{ORA, AND, EOR, ADC, STA, LDA, CMP, SBC};
    alu_mode = '{INDX, ZP, IMM, ABS, INDY, ZPX, ABSY, ABSX};
    shf      = '{ASL, ROL, LSR, ROR};
    for (int i = 0; i < 256; i++) begin
      gold_opc[i] = ILL; gold_mode[i] = IMP; gold_legal[i] = 1'b0;
    end
    for (int a = 0; a < 8; a++)
      for (int m = 0; m < 8; m++)
        if (!(a == 4 && m == 2)) add(a * 32 + m * 4 + 1, alu[a], alu_mode[m]);
    for (int a = 0; a < 4; a++) begin
      add(a * 32 + 8'h0A, shf[a], ACC);
      add(a * 32 + 8'h06, shf[a], ZP);
      add(a * 32 + 8'h0E, shf[a], ABS);
      add(a * 32 + 8'h16, shf[a], ZPX);
      add(a * 32 + 8'h1E, shf[a], ABSX);
    end
    add(8'hC6, DEC, ZP); add(8'hCE, DEC, ABS); add(8'hD6, DEC, ZPX); add(8'hDE, DEC, ABSX);
    add(8'hE6, INC, ZP); add(8'hEE, INC, ABS); add(8'hF6, INC, ZPX); add(8'hFE, INC, ABSX);
    add(8'h86, STX, ZP); add(8'h8E, STX, ABS); add(8'h96, STX, ZPY);
    add(8'hA2, LDX, IMM); add(8'hA6, LDX, ZP); add(8'hAE, LDX, ABS);
    add(8'hB6, LDX, ZPY); add(8'hBE, LDX, ABSY);
    add(8'h8A, TXA, IMP); add(8'hAA, TAX, IMP); add(8'hCA, DEX, IMP);
    add(8'hEA, NOP, IMP); add(8'h9A, TXS, IMP); add(8'hBA, TSX, IMP);
    add(8'h10, BPL, REL); add(8'h30, BMI, REL); add(8'h50, BVC, REL); add(8'h70, BVS, REL);
    add(8'h90, BCC, REL); add(8'hB0, BCS, REL); add(8'hD0, BNE, REL); add(8'hF0, BEQ, REL);
    add(8'h00, BRK, IMP); add(8'h08, PHP, IMP); add(8'h18, CLC, IMP); add(8'h28, PLP, IMP);
    add(8'h38, SEC, IMP); add(8'h40, RTI, IMP); add(8'h48, PHA, IMP); add(8'h58, CLI, IMP);
    add(8'h60, RTS, IMP); add(8'h68, PLA, IMP); add(8'h78, SEI, IMP); add(8'h88, DEY, IMP);
    add(8'h98, TYA, IMP); add(8'hA8, TAY, IMP); add(8'hB8, CLV, IMP); add(8'hC8, INY, IMP);
    add(8'hD8, CLD, IMP); add(8'hE8, INX, IMP); add(8'hF8, SED, IMP);
    add(8'h20, JSR, ABS); add(8'h2C, BIT, ABS); add(8'h4C, JMP, ABS); add(8'h8C, STY, ABS);
    add(8'hAC, LDY, ABS); add(8'hCC, CPY, ABS); add(8'hEC, CPX, ABS);
    add(8'h6C, JMP, IND);
    add(8'h24, BIT, ZP); add(8'h84, STY, ZP); add(8'hA4, LDY, ZP); add(8'hC4, CPY, ZP);
    add(8'hE4, CPX, ZP);
    add(8'h94, STY, ZPX); add(8'hB4, LDY, ZPX);
    add(8'hBC, LDY, ABSX);
    add(8'hA0, LDY, IMM); add(8'hC0, CPY, IMM); add(8'hE0, CPX, IMM);
  endfunction

  task automatic expect_out(input string tag, input opc_t eo, input addmod_t em, input logic ei);
    tests++;
    assert (opcode === eo && mode === em && illegal === ei)
    else begin
      fails++;
      $error("FAIL %s: got %s/%s/%0b, expected %s/%s/%0b", tag,
             opcode.name(), mode.name(), illegal, eo.name(), em.name(), ei);
    end
    $display("[TB] %s instr=%02h rst_n=%0b -> %s/%s ill=%0b", tag, instr, rst_n,
             opcode.name(), mode.name(), illegal);
  endtask

  // Apply one byte, wait one edge, check against the golden map.
  task automatic step(input string tag, input data_t b);
    instr = b;
    @(posedge clk); #1;
    expect_out(tag, gold_opc[b], gold_mode[b], ~gold_legal[b]);
  endtask

  initial begin
    int legal_seen;
    int model_legal;
    data_t dir_bytes[4];
    data_t odd_bytes[7];
    data_t bad_bytes[7];
    build_golden();
    dir_bytes = '{8'hA2, 8'hA6, 8'h4C, 8'hF0};
    odd_bytes = '{8'h6C, 8'hB6, 8'hBE, 8'h0A, 8'h9A, 8'hA1, 8'h91};
    bad_bytes = '{8'h89, 8'h9E, 8'h02, 8'h03, 8'hFF, 8'h80, 8'h04};

    rst_n = 1'b0; instr = 8'hE8;
    repeat (2) begin
      @(posedge clk); #1;
      expect_out("reset", NOP, IMP, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("release_inx", INX, IMP, 1'b0);

    // Hand-written expectations independent of the golden table.
    instr = 8'hA2; @(posedge clk); #1; expect_out("seq_a2", LDX, IMM, 1'b0);
    instr = 8'hA6; @(posedge clk); #1; expect_out("seq_a6", LDX, ZP, 1'b0);
    instr = 8'h4C; @(posedge clk); #1; expect_out("seq_4c", JMP, ABS, 1'b0);
    instr = 8'hF0; @(posedge clk); #1; expect_out("seq_f0", BEQ, REL, 1'b0);
    instr = 8'h6C; @(posedge clk); #1; expect_out("odd_6c", JMP, IND, 1'b0);
    instr = 8'hB6; @(posedge clk); #1; expect_out("odd_b6", LDX, ZPY, 1'b0);
    instr = 8'hBE; @(posedge clk); #1; expect_out("odd_be", LDX, ABSY, 1'b0);
    instr = 8'h0A; @(posedge clk); #1; expect_out("odd_0a", ASL, ACC, 1'b0);
    instr = 8'h9A; @(posedge clk); #1; expect_out("odd_9a", TXS, IMP, 1'b0);
    instr = 8'hA1; @(posedge clk); #1; expect_out("odd_a1", LDA, INDX, 1'b0);
    instr = 8'h91; @(posedge clk); #1; expect_out("odd_91", STA, INDY, 1'b0);
    for (int i = 0; i < 7; i++) begin
      instr = bad_bytes[i]; @(posedge clk); #1;
      expect_out("illegal", ILL, IMP, 1'b1);
    end
    for (int i = 0; i < 4; i++) step("seq_tbl", dir_bytes[i]);
    for (int i = 0; i < 7; i++) step("odd_tbl", odd_bytes[i]);

    model_legal = 0;
    for (int i = 0; i < 256; i++) model_legal += gold_legal[i];
    tests++;
    assert (model_legal == 151)
    else begin
      fails++;
      $error("FAIL model_count: got %0d, expected 151", model_legal);
    end

    legal_seen = 0;
    for (int i = 0; i < 256; i++) begin
      step("sweep", data_t'(i));
      if (illegal === 1'b0) legal_seen++;
    end
    tests++;
    assert (legal_seen == 151)
    else begin
      fails++;
      $error("FAIL legal_count: got %0d, expected 151", legal_seen);
    end

    for (int i = 0; i < 200; i++) step("random", data_t'($urandom_range(0, 255)));

    rst_n = 1'b0; instr = 8'h4C;
    repeat (3) begin
      @(posedge clk); #1;
      expect_out("reset_stream", NOP, IMP, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("release_jmp", JMP, ABS, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
